// File: rtl/mem_line_if.sv
// Cache-fill handshake plus word-RAM read port for the line server.
// The slave modport is the server; the master modport is the cache and RAM side.
interface mem_line_if #(
    parameter int ADDR_W = 32
);
    logic              mem_r;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [127:0]      mem_data;
    logic              ram_rd;
    logic [ADDR_W-3:0] ram_addr;
    logic [31:0]       ram_rdata;
    logic              ram_ack;
    logic              busy;

    modport master (
        output mem_r, mem_addr, ram_rdata, ram_ack,
        input  mem_ready, mem_data, ram_rd, ram_addr, busy
    );

    modport slave (
        input  mem_r, mem_addr, ram_rdata, ram_ack,
        output mem_ready, mem_data, ram_rd, ram_addr, busy
    );
endinterface

// File: rtl/mem_line_server.sv
// Instruction-cache line-fill responder: reads four words of a line from a word RAM,
// assembles a 128-bit line and returns it with a one-cycle ready pulse.
//
// state | meaning
// IDLE  | waiting for mem_r; latches the line address
// LAT   | access-latency countdown before the first read
// FETCH | one-cycle RAM read strobe for word k
// WAIT  | waiting for ram_ack of word k
// DONE  | mem_ready pulse, line valid on mem_data
// REARM | waiting for mem_r to drop before accepting a new fill
module mem_line_server #(
    parameter int ACCESS_LAT = 0,
    parameter int ADDR_W     = 32
) (
    input  logic       clk,
    input  logic       rst,
    mem_line_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LAT   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_REARM = 3'd5;

    localparam logic [3:0] LAT_INIT = 4'(ACCESS_LAT);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-5:0] line_q, line_d;
    logic [1:0]        k_q, k_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [127:0]      data_q, data_d;

    // Byte-within-line bits carry no meaning for a line fill.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.mem_addr[3:0];

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (bus.mem_r) begin
                    line_d = bus.mem_addr[ADDR_W-1:4];
                    k_d    = 2'd0;
                    if (ACCESS_LAT > 0) begin
                        cnt_d   = LAT_INIT;
                        state_d = S_LAT;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_LAT: begin
                cnt_d = cnt_q - 4'd1;
                if (!bus.mem_r) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                // The outstanding read always completes before an abort takes effect.
                if (bus.ram_ack) begin
                    data_d[{k_q, 5'b00000} +: 32] = bus.ram_rdata;
                    if (!bus.mem_r) begin
                        state_d = S_IDLE;
                    end else if (k_q == 2'd3) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE:  state_d = S_REARM;
            S_REARM: begin
                if (!bus.mem_r) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            k_q     <= 2'd0;
            cnt_q   <= 4'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign bus.mem_ready = (state_q == S_DONE);
    assign bus.ram_rd    = (state_q == S_FETCH);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.ram_addr  = {line_q, k_q};
    assign bus.mem_data  = data_q;
endmodule
